// File: rtl/timer_soc_top_pkg.sv
// rtl/timer_soc_top_pkg.sv - shared opcodes, bus map, widths and CPU state type for the timer SoC
// Contents: PC_W/INS_W/DATA_W widths, opcode_e, cpu_state_e, bus addresses,
// CTRL_EN bit index, and the `TIMER path macro to the timer instance.
`ifndef TIMER
`define TIMER soc.u_timer
`endif

package timer_soc_top_pkg;

  localparam int PC_W   = 7;
  localparam int INS_W  = 16;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_MOV  = 4'h7,
    OP_OUT  = 4'h8,
    OP_IN   = 4'h9,
    OP_JMP  = 4'hA,
    OP_JZ   = 4'hB,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } cpu_state_e;

  localparam logic [7:0] TMR_COUNT  = 8'h00;
  localparam logic [7:0] TMR_STATUS = 8'h01;
  localparam logic [7:0] TMR_CTRL   = 8'h02;
  localparam logic [7:0] TMR_PERIOD = 8'h03;
  localparam logic [7:0] PORTA      = 8'h10;

  localparam int CTRL_EN = 7;

endpackage

// File: rtl/timer_soc_top_if.sv
// rtl/timer_soc_top_if.sv - single-cycle APB-like peripheral bus between CPU and peripherals
// Signals: psel (access this cycle), pwrite (1=write), paddr, pwdata, prdata (combinational read).
// Modports: master (CPU), slave (peripheral).
interface timer_soc_top_if;
  import timer_soc_top_pkg::*;

  logic              psel;
  logic              pwrite;
  logic [7:0]        paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;

  modport master (output psel, output pwrite, output paddr, output pwdata, input prdata);
  modport slave  (input psel, input pwrite, input paddr, input pwdata, output prdata);

endinterface

// File: rtl/timer_periph.sv
// rtl/timer_periph.sv - 4-register 8-bit timer: COUNT, STATUS, CTRL, PERIOD
// Ports: clk, rst_n (async active-low), bus (slave modport of timer_soc_top_if).
module timer_periph
  import timer_soc_top_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  timer_soc_top_if.slave  bus
);

  logic [DATA_W-1:0] tmr_reg [0:3];

  logic match;
  logic wr_status;
  logic wr_ctrl;
  logic wr_period;

  assign match     = (tmr_reg[0] == tmr_reg[3]);
  assign wr_status = bus.psel & bus.pwrite & (bus.paddr == TMR_STATUS);
  assign wr_ctrl   = bus.psel & bus.pwrite & (bus.paddr == TMR_CTRL);
  assign wr_period = bus.psel & bus.pwrite & (bus.paddr == TMR_PERIOD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) tmr_reg[i] <= '0;
    end else begin
      // Match reload beats enable, so PERIOD=0 pins COUNT at 0 even while running.
      if (match)                    tmr_reg[0] <= '0;
      else if (tmr_reg[2][CTRL_EN]) tmr_reg[0] <= tmr_reg[0] + 8'd1;

      // Set has priority over a write-one-to-clear in the same cycle.
      tmr_reg[1] <= {7'b0, match | (tmr_reg[1][0] & ~(wr_status & bus.pwdata[0]))};

      if (wr_ctrl)   tmr_reg[2] <= bus.pwdata;
      if (wr_period) tmr_reg[3] <= bus.pwdata;
    end
  end

  always_comb begin
    bus.prdata = '0;
    case (bus.paddr)
      TMR_COUNT:  bus.prdata = tmr_reg[0];
      TMR_STATUS: bus.prdata = tmr_reg[1];
      TMR_CTRL:   bus.prdata = tmr_reg[2];
      TMR_PERIOD: bus.prdata = tmr_reg[3];
      default:    bus.prdata = '0;
    endcase
  end

endmodule

// File: rtl/timer_soc_top.sv
// rtl/timer_soc_top.sv - two-phase 8-bit CPU with 16 GPRs driving a timer and a 4-bit output port
// Ports: clk, rst_n (async active-low), ins_out (instruction at pc, valid by EXEC),
// pc (fetch address), porta (4-bit output port at bus address 0x10).
module timer_soc_top
  import timer_soc_top_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INS_W-1:0] ins_out,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       porta
);

  timer_soc_top_if bus ();

  cpu_state_e        state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic [3:0]        porta_q;
  logic [DATA_W-1:0] gpr_q [0:15];

  logic [3:0]        op;
  logic [3:0]        rd;
  logic [3:0]        rs;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] bus_rdata;
  logic              gpr_we;
  logic [DATA_W-1:0] gpr_wdata;
  logic              exec;

  assign op     = ins_out[15:12];
  assign rd     = ins_out[11:8];
  assign rs     = ins_out[7:4];
  assign imm    = ins_out[7:0];
  assign rd_val = gpr_q[rd];
  assign rs_val = gpr_q[rs];
  assign exec   = (state_q == ST_EXEC);

  assign bus.psel   = exec & ((op == OP_OUT) | (op == OP_IN));
  assign bus.pwrite = (op == OP_OUT);
  assign bus.paddr  = imm;
  assign bus.pwdata = rd_val;

  // PORTA lives in the CPU; the timer returns 0 outside its own addresses.
  assign bus_rdata = bus.prdata | ((bus.paddr == PORTA) ? {4'b0, porta_q} : 8'h00);

  timer_periph u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always_comb begin
    gpr_we    = 1'b0;
    gpr_wdata = rd_val;
    case (op)
      OP_LDI: begin gpr_we = 1'b1; gpr_wdata = imm;             end
      OP_ADD: begin gpr_we = 1'b1; gpr_wdata = rd_val + rs_val; end
      OP_SUB: begin gpr_we = 1'b1; gpr_wdata = rd_val - rs_val; end
      OP_AND: begin gpr_we = 1'b1; gpr_wdata = rd_val & rs_val; end
      OP_OR:  begin gpr_we = 1'b1; gpr_wdata = rd_val | rs_val; end
      OP_XOR: begin gpr_we = 1'b1; gpr_wdata = rd_val ^ rs_val; end
      OP_MOV: begin gpr_we = 1'b1; gpr_wdata = rs_val;          end
      OP_IN:  begin gpr_we = 1'b1; gpr_wdata = bus_rdata;       end
      default: ;
    endcase
  end

  always_comb begin
    pc_d = pc_q + PC_W'(1);
    case (op)
      OP_JMP: pc_d = imm[PC_W-1:0];
      OP_JZ:  if (rd_val == '0) pc_d = imm[PC_W-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      porta_q <= '0;
      for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
    end else begin
      case (state_q)
        ST_FETCH: state_q <= ST_EXEC;
        ST_EXEC: begin
          if (op == OP_HALT) begin
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_FETCH;
            pc_q    <= pc_d;
          end
          if (gpr_we) gpr_q[rd] <= gpr_wdata;
          if (bus.psel && bus.pwrite && (bus.paddr == PORTA)) porta_q <= rd_val[3:0];
        end
        default: ;
      endcase
    end
  end

  assign pc    = pc_q;
  assign porta = porta_q;

endmodule

// File: tb/tb_timer_soc_top.sv
// tb/tb_timer_soc_top.sv - directed self-checking bench for timer_soc_top with a per-edge timer model
module tb_timer_soc_top;

  logic        clk;
  logic        rst_n;
  logic [15:0] ins_out;
  logic [6:0]  pc;
  logic [3:0]  porta;

  logic [15:0] mem [0:127];
  assign ins_out = mem[pc];

  timer_soc_top soc (
    .clk     (clk),
    .rst_n   (rst_n),
    .ins_out (ins_out),
    .pc      (pc),
    .porta   (porta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Timer/port reference state and the hand-computed bus write schedule.
  logic [7:0] m_count, m_status, m_ctrl, m_period;
  logic [3:0] m_porta;
  int         wr_e [0:7];
  logic [7:0] wr_a [0:7];
  logic [7:0] wr_d [0:7];
  int         n_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic add_wr(input int e, input logic [7:0] a, input logic [7:0] d);
    wr_e[n_wr] = e;
    wr_a[n_wr] = a;
    wr_d[n_wr] = d;
    n_wr++;
  endtask

  task automatic model_clear();
    m_count = 8'h00; m_status = 8'h00; m_ctrl = 8'h00; m_period = 8'h00; m_porta = 4'h0;
    edge_n = 0;
  endtask

  task automatic begin_test();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    n_wr = 0;
    model_clear();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_timer();
    chk("count",  32'(`TIMER.tmr_reg[0]), 32'(m_count));
    chk("status", 32'(`TIMER.tmr_reg[1]), 32'(m_status));
    chk("ctrl",   32'(`TIMER.tmr_reg[2]), 32'(m_ctrl));
    chk("period", 32'(`TIMER.tmr_reg[3]), 32'(m_period));
    chk("porta",  32'(porta),             32'(m_porta));
  endtask

  task automatic run(input int n);
    logic [7:0] nc;
    logic       mt;
    logic       clr;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_n++;
      mt  = (m_count == m_period);
      clr = 1'b0;
      nc  = mt ? 8'h00 : (m_ctrl[7] ? m_count + 8'h01 : m_count);
      for (int k = 0; k < n_wr; k++) begin
        if (wr_e[k] == edge_n) begin
          case (wr_a[k])
            8'h01:   clr = wr_d[k][0];
            8'h02:   m_ctrl = wr_d[k];
            8'h03:   m_period = wr_d[k];
            8'h10:   m_porta = wr_d[k][3:0];
            default: ;
          endcase
        end
      end
      m_count  = nc;
      m_status = mt ? 8'h01 : (clr ? 8'h00 : m_status);
      #1;
      check_timer();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    n_wr  = 0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    model_clear();

    // Reset held: everything zero on every edge.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_pc",    32'(pc),                     32'd0);
      chk("rst_porta", 32'(porta),                  32'd0);
      chk("rst_t0",    32'(`TIMER.tmr_reg[0]),      32'd0);
      chk("rst_t1",    32'(`TIMER.tmr_reg[1]),      32'd0);
      chk("rst_t2",    32'(`TIMER.tmr_reg[2]),      32'd0);
      chk("rst_t3",    32'(`TIMER.tmr_reg[3]),      32'd0);
    end

    // PERIOD=5, clear STATUS, enable: COUNT 0..5 repeating, STATUS set at the wrap.
    begin_test();
    mem[0] = 16'h1105; mem[1] = 16'h8103; mem[2] = 16'h1280; mem[3] = 16'h1401;
    mem[4] = 16'h8401; mem[5] = 16'h8202; mem[6] = 16'hA006;
    add_wr(4, 8'h03, 8'h05);
    add_wr(10, 8'h01, 8'h01);
    add_wr(12, 8'h02, 8'h80);
    release_reset();
    run(40);

    // Enabled with PERIOD=0 over a full pc wrap: COUNT pinned at 0.
    begin_test();
    mem[0] = 16'h1280; mem[1] = 16'h8202;
    add_wr(4, 8'h02, 8'h80);
    add_wr(260, 8'h02, 8'h80);
    release_reset();
    run(254);
    chk("pc_127", 32'(pc), 32'd127);
    run(2);
    chk("pc_wrap", 32'(pc), 32'd0);
    run(6);

    // PERIOD lowered below COUNT: count on through 0xFF, wrap, then match 0x10.
    begin_test();
    mem[0] = 16'h11FF; mem[1] = 16'h8103; mem[2] = 16'h1280; mem[3] = 16'h8202;
    mem[4] = 16'h1310; mem[36] = 16'h8303; mem[37] = 16'hA025;
    add_wr(4, 8'h03, 8'hFF);
    add_wr(8, 8'h02, 8'h80);
    add_wr(74, 8'h03, 8'h10);
    release_reset();
    run(300);

    // PORTA write and JMP 0 loop: pc 0,1,2,0 each held two cycles.
    begin_test();
    mem[0] = 16'h130A; mem[1] = 16'h8310; mem[2] = 16'hA000;
    add_wr(4, 8'h10, 8'h0A);
    release_reset();
    for (int i = 0; i < 12; i++) begin
      run(1);
      chk("pc_loop", 32'(pc), 32'((edge_n / 2) % 3));
    end

    // IN of CTRL to PORTA, unmapped IN, JZ not-taken/taken, HALT; then async reset mid-count.
    begin_test();
    mem[0] = 16'h1107; mem[1] = 16'h8103; mem[2] = 16'h1285; mem[3] = 16'h8202;
    mem[4] = 16'h9502; mem[5] = 16'h8510; mem[6] = 16'h9677; mem[7] = 16'hB10C;
    mem[8] = 16'hB60A; mem[9] = 16'h8110; mem[10] = 16'hF000;
    add_wr(4, 8'h03, 8'h07);
    add_wr(8, 8'h02, 8'h85);
    add_wr(12, 8'h10, 8'h85);
    release_reset();
    run(43);
    chk("pc_halt", 32'(pc), 32'd10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count",  32'(`TIMER.tmr_reg[0]), 32'd0);
    chk("arst_ctrl",   32'(`TIMER.tmr_reg[2]), 32'd0);
    chk("arst_period", 32'(`TIMER.tmr_reg[3]), 32'd0);
    chk("arst_porta",  32'(porta),             32'd0);
    chk("arst_pc",     32'(pc),                32'd0);
    model_clear();
    @(negedge clk);
    release_reset();
    run(43);
    chk("pc_halt_again", 32'(pc), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
